mining_job_scheduler: RTL and testbench
=======================================

// Module: mining_job_scheduler
// PURPOSE
// - Sequences the multi-core double-SHA nonce search engine for one mining job at a time.
// - Accepts a job (header without nonce, target, nonce range) and launches engine batches of NUM_CORES nonces.
// - Checks each batch's best hash against the target; stops on hit, range exhaustion, abort or engine timeout.
// - Sits between the host/job FIFO and the hashing array; returns one result record per job.
// PARAMETERS
// - NUM_CORES   10      nonces evaluated per engine batch (engine core count); 1..255
// - TIMEOUT     4096    max cycles from engine_start to engine_done before error; >=2
// PORTS
// - clk_i              in   1    clock
// - rst_i              in   1    synchronous active-high reset
// - job_valid          in   1    job offered
// - job_ready          out  1    scheduler can accept a job (IDLE)
// - job_header         in   608  block header without nonce
// - job_target         in   256  target; hit when hash value <= target
// - job_nonce_start    in   32   first nonce of range
// - job_nonce_end      in   32   last nonce of range (inclusive)
// - abort              in   1    cancel current job
// - engine_rst         out  1    one-cycle engine reset pulse
// - engine_start       out  1    one-cycle batch launch pulse
// - engine_header      out  608  registered job header
// - engine_nonce_base  out  32   first nonce of batch; engine covers base..base+NUM_CORES-1
// - engine_done        in   1    batch complete (single-cycle pulse)
// - engine_hash        in   256  best hash of batch, engine byte order
// - engine_hash_nonce  in   32   nonce producing engine_hash
// - res_valid          out  1    result record valid
// - res_ready          in   1    consumer accepts result
// - res_status         out  2    0=found 1=exhausted 2=aborted 3=timeout
// - res_nonce          out  32   winning nonce (0 unless found)
// - res_hash           out  256  winning hash, engine byte order (0 unless found)
// - busy               out  1    state != IDLE
// - batch_count        out  32   batches launched for current job, saturating
// BEHAVIOUR
// - Reset: state IDLE; job_ready=1; engine_start=0; engine_rst=1 for the reset cycle; res_valid=0;
//   res_status/res_nonce/res_hash/engine_nonce_base/batch_count=0; busy=0; engine_header=0.
// - Hash value for comparison = byte-reversed engine_hash (byte 31 of engine order is the MSB).
// - IDLE: job_valid&job_ready -> latch job, base=nonce_start, batch_count=0, go RST. job_ready=0 outside IDLE.
//   If nonce_end < nonce_start: go straight to REPORT, status=exhausted, no engine activity.
// - RST: engine_rst=1 for one cycle -> LAUNCH.
// - LAUNCH: engine_start=1 one cycle, batch_count++ (saturate at 2^32-1), timer cleared -> WAIT.
// - WAIT: timer++ each cycle; engine_done -> EVAL (latch hash/nonce); timer reaches TIMEOUT -> REPORT
//   status=timeout with engine_rst pulsed. engine_done outside WAIT ignored.
// - EVAL (1 cycle): hit = value<=target AND engine_hash_nonce<=nonce_end -> REPORT status=found.
//   Else if base+NUM_CORES > nonce_end (33-bit compare, covers 2^32 wrap) -> REPORT status=exhausted.
//   Else base+=NUM_CORES -> RST.
// - REPORT: res_valid=1, fields stable until res_valid&res_ready; then IDLE, job_ready=1 next cycle.
// - abort in RST/LAUNCH/WAIT/EVAL: engine_rst pulse, REPORT status=aborted next cycle; abort wins over
//   engine_done/timeout in the same cycle. abort in IDLE/REPORT ignored.
// - Latency: job accept to first engine_start = 2 cycles; engine_done to next engine_start = 3 cycles;
//   engine_done to res_valid on hit = 2 cycles.
// - rst_i mid-job: immediate return to reset values; no result emitted for the lost job.
// TESTING
// - Range 0..29, target all-ones -> batch 1 base=0 hit, res_status=0, res_nonce=engine nonce, batch_count=1.
// - Range 0..29, target 0, no hit -> bases 0,10,20 launched, res_status=1, batch_count=3.
// - Range 5..3 -> res_status=1 with zero engine_start pulses, res_valid 1 cycle after accept.
// - Range FFFFFFF0..FFFFFFFF, target 0 -> bases FFFFFFF0,FFFFFFFA, no wrap to 0, status=1.
// - Hit with engine_hash_nonce=31 on range 20..30 -> ignored, status=1 (nonce beyond end).
// - engine_done withheld -> res_status=3 exactly TIMEOUT cycles after engine_start; abort during WAIT -> status=2;
//   res_ready held low 20 cycles -> result fields stable, job_ready stays 0.

Source files
------------

// File: rtl/mining_job_scheduler_if.sv
// Handshake and data bundle between the job scheduler and its neighbours:
// the host job/result FIFOs on one side and the hashing engine array on the other.
// The master modport is the scheduler's view; slave is the host/engine view.
interface mining_job_scheduler_if;
    // Job intake
    logic         job_valid;
    logic         job_ready;
    logic [607:0] job_header;
    logic [255:0] job_target;
    logic [31:0]  job_nonce_start;
    logic [31:0]  job_nonce_end;
    logic         abort;

    // Engine control and batch results
    logic         engine_rst;
    logic         engine_start;
    logic [607:0] engine_header;
    logic [31:0]  engine_nonce_base;
    logic         engine_done;
    logic [255:0] engine_hash;
    logic [31:0]  engine_hash_nonce;

    // Result record and status
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_status;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
    logic [31:0]  batch_count;

    modport master (
        input  job_valid, job_header, job_target, job_nonce_start, job_nonce_end, abort,
        input  engine_done, engine_hash, engine_hash_nonce, res_ready,
        output job_ready, engine_rst, engine_start, engine_header, engine_nonce_base,
        output res_valid, res_status, res_nonce, res_hash, busy, batch_count
    );

    modport slave (
        output job_valid, job_header, job_target, job_nonce_start, job_nonce_end, abort,
        output engine_done, engine_hash, engine_hash_nonce, res_ready,
        input  job_ready, engine_rst, engine_start, engine_header, engine_nonce_base,
        input  res_valid, res_status, res_nonce, res_hash, busy, batch_count
    );
endinterface

// File: rtl/mining_job_scheduler.sv
// Mining job scheduler: accepts one job at a time, launches the nonce-search
// engine in batches of NUM_CORES nonces, checks each batch's best hash against
// the target and returns one result record (found/exhausted/aborted/timeout).
module mining_job_scheduler #(
    parameter int unsigned NUM_CORES = 10,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mining_job_scheduler_if.master bus
);
    localparam int unsigned    TW         = $clog2(TIMEOUT + 1);
    // WAIT exits on this timer value so the result lands exactly TIMEOUT cycles after engine_start.
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 2);
    localparam logic [32:0]    STEP       = 33'(NUM_CORES);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_LAUNCH, S_WAIT, S_EVAL, S_REPORT
    } state_t;

    typedef enum logic [1:0] {
        ST_FOUND     = 2'd0,
        ST_EXHAUSTED = 2'd1,
        ST_ABORTED   = 2'd2,
        ST_TIMEOUT   = 2'd3
    } status_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [255:0]  target_q;
    logic [31:0]   nonce_end_q;
    logic [255:0]  hash_q;
    logic [31:0]   hash_nonce_q;

    logic [255:0]  hash_value;
    logic [32:0]   next_base;
    logic          hit;
    logic          last_batch;

    // Numeric hash value: the engine emits byte 0 in bits [255:248], so byte 31 becomes the MSB.
    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        hash_value = '0;
        for (int i = 0; i < 32; i++) begin
            hash_value[8*i +: 8] = hash_q[8*(31-i) +: 8];
        end
    end

    // The 33-bit sum keeps a batch that reaches past 2^32-1 from wrapping back to a small base.
    assign next_base  = {1'b0, bus.engine_nonce_base} + STEP;
    assign last_batch = next_base > {1'b0, nonce_end_q};
    assign hit        = (hash_value <= target_q) && (hash_nonce_q <= nonce_end_q);

    // Job sequencing FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (rst_i) begin
            state_q               <= S_IDLE;
            timer_q               <= '0;
            target_q              <= '0;
            nonce_end_q           <= '0;
            hash_q                <= '0;
            hash_nonce_q          <= '0;
            bus.job_ready         <= 1'b1;
            bus.engine_rst        <= 1'b1;
            bus.engine_start      <= 1'b0;
            bus.engine_header     <= '0;
            bus.engine_nonce_base <= '0;
            bus.res_valid         <= 1'b0;
            bus.res_status        <= '0;
            bus.res_nonce         <= '0;
            bus.res_hash          <= '0;
            bus.busy              <= 1'b0;
            bus.batch_count       <= '0;
        end else begin
            bus.engine_rst   <= 1'b0;
            bus.engine_start <= 1'b0;

            if (bus.abort && (state_q inside {S_RST, S_LAUNCH, S_WAIT, S_EVAL})) begin
                // Abort beats a same-cycle engine_done or timeout.
                state_q        <= S_REPORT;
                bus.engine_rst <= 1'b1;
                bus.res_valid  <= 1'b1;
                bus.res_status <= ST_ABORTED;
                bus.res_nonce  <= '0;
                bus.res_hash   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.job_valid) begin
                            bus.engine_header     <= bus.job_header;
                            target_q              <= bus.job_target;
                            nonce_end_q           <= bus.job_nonce_end;
                            bus.engine_nonce_base <= bus.job_nonce_start;
                            bus.batch_count       <= '0;
                            bus.job_ready         <= 1'b0;
                            bus.busy              <= 1'b1;
                            if (bus.job_nonce_end < bus.job_nonce_start) begin
                                // Empty range: report without touching the engine.
                                state_q        <= S_REPORT;
                                bus.res_valid  <= 1'b1;
                                bus.res_status <= ST_EXHAUSTED;
                                bus.res_nonce  <= '0;
                                bus.res_hash   <= '0;
                            end else begin
                                state_q        <= S_RST;
                                bus.engine_rst <= 1'b1;
                            end
                        end
                    end

                    S_RST: begin
                        state_q          <= S_LAUNCH;
                        bus.engine_start <= 1'b1;
                        timer_q          <= '0;
                        if (bus.batch_count != '1) begin
                            bus.batch_count <= bus.batch_count + 32'd1;
                        end
                    end

                    S_LAUNCH: begin
                        state_q <= S_WAIT;
                    end

                    S_WAIT: begin
                        if (bus.engine_done) begin
                            hash_q       <= bus.engine_hash;
                            hash_nonce_q <= bus.engine_hash_nonce;
                            state_q      <= S_EVAL;
                        end else if (timer_q == TIMER_LAST) begin
                            state_q        <= S_REPORT;
                            bus.engine_rst <= 1'b1;
                            bus.res_valid  <= 1'b1;
                            bus.res_status <= ST_TIMEOUT;
                            bus.res_nonce  <= '0;
                            bus.res_hash   <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end

                    S_EVAL: begin
                        if (hit) begin
                            state_q        <= S_REPORT;
                            bus.res_valid  <= 1'b1;
                            bus.res_status <= ST_FOUND;
                            bus.res_nonce  <= hash_nonce_q;
                            bus.res_hash   <= hash_q;
                        end else if (last_batch) begin
                            state_q        <= S_REPORT;
                            bus.res_valid  <= 1'b1;
                            bus.res_status <= ST_EXHAUSTED;
                            bus.res_nonce  <= '0;
                            bus.res_hash   <= '0;
                        end else begin
                            bus.engine_nonce_base <= next_base[31:0];
                            state_q               <= S_RST;
                            bus.engine_rst        <= 1'b1;
                        end
                    end

                    S_REPORT: begin
                        if (bus.res_ready) begin
                            state_q       <= S_IDLE;
                            bus.res_valid <= 1'b0;
                            bus.job_ready <= 1'b1;
                            bus.busy      <= 1'b0;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mining_job_scheduler.sv
// Directed testbench for mining_job_scheduler: the bench plays both host and
// hashing engine, and compares outputs against hand-computed values.
module tb_mining_job_scheduler;
    localparam int unsigned NUM_CORES = 10;
    localparam int unsigned TIMEOUT   = 16;
    localparam logic [255:0] ONES     = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   start_cnt = 0;

    mining_job_scheduler_if bus_if ();

    mining_job_scheduler #(
        .NUM_CORES(NUM_CORES),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Count engine_start pulses across the whole run.
    always @(posedge clk) begin
        if (bus_if.engine_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [31:0] s, input logic [31:0] e,
                          input logic [255:0] tgt, input logic [607:0] hdr);
        bus_if.job_valid       = 1'b1;
        bus_if.job_nonce_start = s;
        bus_if.job_nonce_end   = e;
        bus_if.job_target      = tgt;
        bus_if.job_header      = hdr;
        step();
        bus_if.job_valid = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!bus_if.engine_start && cyc < 64) begin
            step();
            cyc++;
        end
        check("start_seen", 256'(bus_if.engine_start), 256'(1));
    endtask

    // Wait for a launch, check its base, then answer with done two cycles into WAIT.
    task automatic batch(input string tag, input logic [31:0] exp_base,
                         input logic [255:0] h, input logic [31:0] n, output int lat);
        wait_start(lat);
        check({tag, "_base"}, 256'(bus_if.engine_nonce_base), 256'(exp_base));
        step();
        step();
        bus_if.engine_done       = 1'b1;
        bus_if.engine_hash       = h;
        bus_if.engine_hash_nonce = n;
        step();
        bus_if.engine_done = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!bus_if.res_valid && n < 64) begin
            step();
            n++;
        end
        check("res_valid_seen", 256'(bus_if.res_valid), 256'(1));
    endtask

    task automatic release_result();
        bus_if.res_ready = 1'b1;
        step();
        bus_if.res_ready = 1'b0;
        check("rel_valid", 256'(bus_if.res_valid), 256'(0));
        check("rel_ready", 256'(bus_if.job_ready), 256'(1));
        check("rel_busy",  256'(bus_if.busy),      256'(0));
    endtask

    initial begin
        int lat;
        int k;
        int s0;
        logic [607:0] hdr;
        hdr = {19{32'hDEADBEEF}};

        bus_if.job_valid         = 1'b0;
        bus_if.job_header        = '0;
        bus_if.job_target        = '0;
        bus_if.job_nonce_start   = '0;
        bus_if.job_nonce_end     = '0;
        bus_if.abort             = 1'b0;
        bus_if.engine_done       = 1'b0;
        bus_if.engine_hash       = '0;
        bus_if.engine_hash_nonce = '0;
        bus_if.res_ready         = 1'b0;

        // Reset values while rst is held
        step();
        step();
        check("rst_job_ready",  256'(bus_if.job_ready),         256'(1));
        check("rst_engine_rst", 256'(bus_if.engine_rst),        256'(1));
        check("rst_start",      256'(bus_if.engine_start),      256'(0));
        check("rst_res_valid",  256'(bus_if.res_valid),         256'(0));
        check("rst_busy",       256'(bus_if.busy),              256'(0));
        check("rst_bc",         256'(bus_if.batch_count),       256'(0));
        check("rst_base",       256'(bus_if.engine_nonce_base), 256'(0));
        check("rst_status",     256'(bus_if.res_status),        256'(0));
        check("rst_header",     bus_if.engine_header[255:0],    256'(0));
        rst = 1'b0;
        step();
        check("post_rst_erst",  256'(bus_if.engine_rst),        256'(0));

        // Abort while idle is ignored
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        check("idle_abort_busy",  256'(bus_if.busy),      256'(0));
        check("idle_abort_ready", 256'(bus_if.job_ready), 256'(1));

        // Hit on the first batch, target all ones
        s0 = start_cnt;
        submit(32'd0, 32'd29, ONES, hdr);
        check("acc_ready", 256'(bus_if.job_ready),    256'(0));
        check("acc_busy",  256'(bus_if.busy),         256'(1));
        check("acc_erst",  256'(bus_if.engine_rst),   256'(1));
        check("acc_start", 256'(bus_if.engine_start), 256'(0));
        check("acc_hdr_lo", bus_if.engine_header[255:0],   hdr[255:0]);
        check("acc_hdr_hi", bus_if.engine_header[607:352], hdr[607:352]);
        batch("hit", 32'd0, 256'hABCD, 32'd7, lat);
        check("hit_accept_lat", 256'(lat), 256'(1));
        check("hit_eval_valid", 256'(bus_if.res_valid), 256'(0));
        step();
        check("hit_valid",  256'(bus_if.res_valid),   256'(1));
        check("hit_status", 256'(bus_if.res_status),  256'(0));
        check("hit_nonce",  256'(bus_if.res_nonce),   256'(7));
        check("hit_hash",   bus_if.res_hash,          256'hABCD);
        check("hit_bc",     256'(bus_if.batch_count), 256'(1));
        check("hit_starts", 256'(start_cnt - s0),     256'(1));
        release_result();

        // Target zero: three batches, exhausted
        s0 = start_cnt;
        submit(32'd0, 32'd29, 256'h0, hdr);
        batch("ex0", 32'd0,  256'h5, 32'd3,  lat);
        batch("ex1", 32'd10, 256'h5, 32'd13, lat);
        check("done_to_start_lat", 256'(lat), 256'(2));
        batch("ex2", 32'd20, 256'h5, 32'd23, lat);
        wait_result();
        check("ex_status", 256'(bus_if.res_status),  256'(1));
        check("ex_nonce",  256'(bus_if.res_nonce),   256'(0));
        check("ex_hash",   bus_if.res_hash,          256'(0));
        check("ex_bc",     256'(bus_if.batch_count), 256'(3));
        check("ex_starts", 256'(start_cnt - s0),     256'(3));
        release_result();

        // Byte order: engine byte 31 sits in bits [7:0] and is the numeric MSB
        submit(32'd0, 32'd19, 256'h1 << 240, hdr);
        batch("bo0", 32'd0,  256'h1,        32'd3,  lat);
        batch("bo1", 32'd10, 256'h1 << 248, 32'd12, lat);
        wait_result();
        check("bo_status", 256'(bus_if.res_status),  256'(0));
        check("bo_nonce",  256'(bus_if.res_nonce),   256'(12));
        check("bo_hash",   bus_if.res_hash,          256'h1 << 248);
        check("bo_bc",     256'(bus_if.batch_count), 256'(2));
        release_result();

        // Empty range: immediate exhausted, no engine activity
        s0 = start_cnt;
        submit(32'd5, 32'd3, ONES, hdr);
        check("empty_valid",  256'(bus_if.res_valid),    256'(1));
        check("empty_status", 256'(bus_if.res_status),   256'(1));
        check("empty_erst",   256'(bus_if.engine_rst),   256'(0));
        check("empty_start",  256'(bus_if.engine_start), 256'(0));
        release_result();
        check("empty_starts", 256'(start_cnt - s0), 256'(0));

        // Top of nonce space: no wrap to base 0
        s0 = start_cnt;
        submit(32'hFFFF_FFF0, 32'hFFFF_FFFF, 256'h0, hdr);
        batch("wr0", 32'hFFFF_FFF0, 256'h9, 32'hFFFF_FFF1, lat);
        batch("wr1", 32'hFFFF_FFFA, 256'h9, 32'hFFFF_FFFB, lat);
        wait_result();
        check("wr_status", 256'(bus_if.res_status),        256'(1));
        check("wr_bc",     256'(bus_if.batch_count),       256'(2));
        check("wr_base",   256'(bus_if.engine_nonce_base), 256'(32'hFFFF_FFFA));
        check("wr_starts", 256'(start_cnt - s0),           256'(2));
        release_result();

        // Hash nonce beyond range end is not a hit
        submit(32'd20, 32'd30, ONES, hdr);
        batch("oor0", 32'd20, 256'hABCD, 32'd31, lat);
        batch("oor1", 32'd30, 256'hABCD, 32'd35, lat);
        wait_result();
        check("oor_status", 256'(bus_if.res_status),  256'(1));
        check("oor_nonce",  256'(bus_if.res_nonce),   256'(0));
        check("oor_bc",     256'(bus_if.batch_count), 256'(2));
        release_result();

        // Engine timeout, then a stalled result consumer
        submit(32'd0, 32'd29, ONES, hdr);
        wait_start(lat);
        k = 0;
        while (!bus_if.res_valid && k < 200) begin
            step();
            k++;
        end
        check("to_cycles", 256'(k),                  256'(TIMEOUT));
        check("to_status", 256'(bus_if.res_status),  256'(3));
        check("to_erst",   256'(bus_if.engine_rst),  256'(1));
        check("to_nonce",  256'(bus_if.res_nonce),   256'(0));
        bus_if.job_valid       = 1'b1;
        bus_if.job_nonce_start = 32'd5;
        bus_if.job_nonce_end   = 32'd3;
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall_valid",  256'(bus_if.res_valid),  256'(1));
            check("stall_status", 256'(bus_if.res_status), 256'(3));
            check("stall_ready",  256'(bus_if.job_ready),  256'(0));
            check("stall_erst",   256'(bus_if.engine_rst), 256'(0));
        end
        bus_if.job_valid = 1'b0;
        release_result();

        // Abort during WAIT beats a same-cycle engine_done
        submit(32'd0, 32'd29, ONES, hdr);
        wait_start(lat);
        step();
        step();
        bus_if.abort             = 1'b1;
        bus_if.engine_done       = 1'b1;
        bus_if.engine_hash       = 256'hABCD;
        bus_if.engine_hash_nonce = 32'd4;
        step();
        bus_if.abort       = 1'b0;
        bus_if.engine_done = 1'b0;
        check("ab_valid",  256'(bus_if.res_valid),  256'(1));
        check("ab_status", 256'(bus_if.res_status), 256'(2));
        check("ab_erst",   256'(bus_if.engine_rst), 256'(1));
        check("ab_nonce",  256'(bus_if.res_nonce),  256'(0));
        check("ab_hash",   bus_if.res_hash,         256'(0));
        release_result();

        // Reset mid-job drops the job without a result
        submit(32'd0, 32'd29, ONES, hdr);
        wait_start(lat);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_ready", 256'(bus_if.job_ready),      256'(1));
        check("mrst_valid", 256'(bus_if.res_valid),      256'(0));
        check("mrst_bc",    256'(bus_if.batch_count),    256'(0));
        check("mrst_hdr",   bus_if.engine_header[255:0], 256'(0));
        check("mrst_erst",  256'(bus_if.engine_rst),     256'(1));
        bus_if.engine_done = 1'b1;
        step();
        bus_if.engine_done = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mrst_after_valid", 256'(bus_if.res_valid), 256'(0));
        check("mrst_after_busy",  256'(bus_if.busy),      256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
